// File: rtl/fifo_write_arbiter.sv
// Write-side scheduler for the CPU->FPGA async FIFO: round-robin arbitration with packet locking,
// requester-tagged beats staged in a single output register that honours the FIFO's full flag.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input  logic                          w_clk,
  input  logic                          w_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          w_en,
  output logic [WIDTH-1:0]              data_in,
  input  logic                          full,
  output logic [TAG_WIDTH-1:0]          grant_id,
  output logic                          busy
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                 r_state, w_state_nxt;
  logic [TAG_WIDTH-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [TAG_WIDTH-1:0]   r_lock_id, w_lock_id_nxt;
  logic [TAG_WIDTH-1:0]   r_grant_id;
  logic                   r_out_valid;
  logic [WIDTH-1:0]       r_out_word;

  logic                   w_slot_free;
  logic [NUM_REQ-1:0]     w_rot;
  logic                   w_arb_found;
  logic [TAG_WIDTH-1:0]   w_arb_idx;
  int                     w_sum;
  logic [TAG_WIDTH-1:0]   w_grant;
  logic [TAG_WIDTH-1:0]   w_grant_inc;
  logic                   w_grant_vld;
  logic                   w_sel_valid;
  logic                   w_sel_last;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic                   w_accept;

  assign w_slot_free = !r_out_valid || !full;

  // Rotate valids so bit 0 is the requester at rr_ptr; the first set bit wins.
  assign w_rot = NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);

  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_sum       = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!w_arb_found && w_rot[k]) begin
        w_arb_found = 1'b1;
        w_sum       = int'(r_rr_ptr) + k;
        if (w_sum >= int'(NUM_REQ)) w_sum = w_sum - int'(NUM_REQ);
        w_arb_idx   = TAG_WIDTH'(w_sum);
      end
    end
  end

  assign w_grant     = (r_state == StLocked) ? r_lock_id : w_arb_idx;
  assign w_grant_vld = (r_state == StLocked) || w_arb_found;
  assign w_grant_inc = (w_grant == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : w_grant + TAG_WIDTH'(1);

  always_comb begin
    req_ready   = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_grant == TAG_WIDTH'(i)) begin
        req_ready[i] = w_grant_vld && w_slot_free;
        w_sel_valid  = req_valid[i];
        w_sel_last   = req_last[i];
        w_sel_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_accept = w_sel_valid && w_grant_vld && w_slot_free;

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_lock_id_nxt = r_lock_id;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_sel_last) begin
            w_rr_ptr_nxt = w_grant_inc;
          end else begin
            w_state_nxt   = StLocked;
            w_lock_id_nxt = w_grant;
          end
        end
      end
      StLocked: begin
        // Holds here until the locked requester finishes; other valids are ignored.
        if (w_accept && w_sel_last) begin
          w_state_nxt  = StIdle;
          w_rr_ptr_nxt = w_grant_inc;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= StIdle;
      r_rr_ptr    <= '0;
      r_lock_id   <= '0;
      r_grant_id  <= '0;
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_lock_id <= w_lock_id_nxt;
      if (w_accept) begin
        r_out_word  <= {w_grant, w_sel_data};
        r_out_valid <= 1'b1;
        r_grant_id  <= w_grant;
      end else if (r_out_valid && !full) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign w_en     = r_out_valid && !full;
  assign data_in  = r_out_word;
  assign grant_id = r_grant_id;
  assign busy     = (r_state == StLocked);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed, table-driven bench for fifo_write_arbiter: per-cycle vectors with hand-computed
// expectations plus a hand-written reset-mid-packet sequence.
module tb_fifo_write_arbiter;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned TAG_WIDTH  = 4;
  localparam int unsigned WIDTH      = DATA_WIDTH + TAG_WIDTH;

  logic                          w_clk;
  logic                          w_rst_n;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          w_en;
  logic [WIDTH-1:0]              data_in;
  logic                          full;
  logic [TAG_WIDTH-1:0]          grant_id;
  logic                          busy;

  fifo_write_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .TAG_WIDTH (TAG_WIDTH),
    .WIDTH     (WIDTH)
  ) dut (
    .w_clk    (w_clk),
    .w_rst_n  (w_rst_n),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_data (req_data),
    .req_ready(req_ready),
    .w_en     (w_en),
    .data_in  (data_in),
    .full     (full),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic [7:0] seq;
    logic [3:0] exp_ready;
    logic       exp_wen;
    logic [3:0] exp_tag;
    logic [7:0] exp_seq;
    logic [3:0] exp_gid;
    logic       exp_busy;
    logic       chk_d;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Payload of requester i for sequence number s; distinct per requester and per beat.
  function automatic logic [31:0] pay(input int i, input logic [7:0] s);
    return {4'(i + 1), 4'hA, 16'h5A5A, s};
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic f,
                              input logic [7:0] s, input logic [3:0] rdy, input logic wen,
                              input logic [3:0] tag, input logic [7:0] es, input logic [3:0] gid,
                              input logic bsy, input logic cd);
    vec_t r;
    r.valid = v; r.last = l; r.full = f; r.seq = s;
    r.exp_ready = rdy; r.exp_wen = wen; r.exp_tag = tag; r.exp_seq = es;
    r.exp_gid = gid; r.exp_busy = bsy; r.chk_d = cd;
    return r;
  endfunction

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f,
                       input logic [7:0] s);
    req_valid = v;
    req_last  = l;
    full      = f;
    for (int i = 0; i < int'(NUM_REQ); i++) req_data[i*DATA_WIDTH +: DATA_WIDTH] = pay(i, s);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Single beat, round-robin cycle with wrap, locked 3-beat packet, full stall, one-beat
    // accept into an empty register under full, and a locked requester dropping valid.
    vecs.push_back(mk(4'b0100, 4'b0100, 1'b0, 8'h01, 4'b0100, 1'b0, 4'd0, 8'h00, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b1, 4'd2, 8'h01, 4'd2, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1111, 1'b0, 8'h02, 4'b1000, 1'b0, 4'd0, 8'h00, 4'd2, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b1111, 1'b0, 8'h03, 4'b0001, 1'b1, 4'd3, 8'h02, 4'd3, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1111, 1'b0, 8'h04, 4'b0010, 1'b1, 4'd0, 8'h03, 4'd0, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1111, 1'b0, 8'h05, 4'b0100, 1'b1, 4'd1, 8'h04, 4'd1, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1111, 1'b0, 8'h06, 4'b1000, 1'b1, 4'd2, 8'h05, 4'd2, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1111, 1'b0, 8'h07, 4'b0001, 1'b1, 4'd3, 8'h06, 4'd3, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1011, 4'b1001, 1'b0, 8'h08, 4'b0010, 1'b1, 4'd0, 8'h07, 4'd0, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1011, 4'b1001, 1'b0, 8'h09, 4'b0010, 1'b1, 4'd1, 8'h08, 4'd1, 1'b1, 1'b1));
    vecs.push_back(mk(4'b1011, 4'b1011, 1'b0, 8'h0A, 4'b0010, 1'b1, 4'd1, 8'h09, 4'd1, 1'b1, 1'b1));
    vecs.push_back(mk(4'b1001, 4'b1001, 1'b0, 8'h0B, 4'b1000, 1'b1, 4'd1, 8'h0A, 4'd1, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0001, 4'b0001, 1'b0, 8'h0C, 4'b0001, 1'b1, 4'd3, 8'h0B, 4'd3, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b1, 4'd0, 8'h0C, 4'd0, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0010, 4'b0000, 1'b0, 8'h10, 4'b0010, 1'b0, 4'd0, 8'h00, 4'd0, 1'b0, 1'b0));
    for (int n = 0; n < 5; n++) begin
      vecs.push_back(mk(4'b0010, 4'b0000, 1'b1, 8'h11, 4'b0000, 1'b0, 4'd1, 8'h10, 4'd1, 1'b1,
                        1'b1));
    end
    vecs.push_back(mk(4'b0010, 4'b0000, 1'b0, 8'h11, 4'b0010, 1'b1, 4'd1, 8'h10, 4'd1, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0010, 4'b0010, 1'b0, 8'h12, 4'b0010, 1'b1, 4'd1, 8'h11, 4'd1, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b1, 4'd1, 8'h12, 4'd1, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0100, 4'b0100, 1'b1, 8'h13, 4'b0100, 1'b0, 4'd0, 8'h00, 4'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0, 4'd2, 8'h13, 4'd2, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b1, 4'd2, 8'h13, 4'd2, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0100, 4'b0000, 1'b0, 8'h14, 4'b0100, 1'b0, 4'd0, 8'h00, 4'd2, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0001, 4'b0001, 1'b0, 8'h15, 4'b0100, 1'b1, 4'd2, 8'h14, 4'd2, 1'b1, 1'b1));
    for (int n = 0; n < 3; n++) begin
      vecs.push_back(mk(4'b0001, 4'b0001, 1'b0, 8'h15, 4'b0100, 1'b0, 4'd0, 8'h00, 4'd2, 1'b1,
                        1'b0));
    end
    vecs.push_back(mk(4'b0101, 4'b0101, 1'b0, 8'h16, 4'b0100, 1'b0, 4'd0, 8'h00, 4'd2, 1'b1, 1'b0));
    vecs.push_back(mk(4'b0001, 4'b0001, 1'b0, 8'h17, 4'b0001, 1'b1, 4'd2, 8'h16, 4'd2, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b1, 4'd0, 8'h17, 4'd0, 1'b0, 1'b1));

    w_rst_n = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 8'h00);
    repeat (3) @(posedge w_clk);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    #1;
    check("reset w_en", 64'(w_en), 64'd0);
    check("reset data_in", 64'(data_in), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset grant_id", 64'(grant_id), 64'd0);
    check("reset req_ready", 64'(req_ready), 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge w_clk);
      drive(vecs[i].valid, vecs[i].last, vecs[i].full, vecs[i].seq);
      #1;
      check($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
      check($sformatf("v%0d w_en", i), 64'(w_en), 64'(vecs[i].exp_wen));
      check($sformatf("v%0d grant_id", i), 64'(grant_id), 64'(vecs[i].exp_gid));
      check($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].exp_busy));
      if (vecs[i].chk_d) begin
        check($sformatf("v%0d data_in", i), 64'(data_in),
              64'({vecs[i].exp_tag, pay(int'(vecs[i].exp_tag), vecs[i].exp_seq)}));
      end
    end

    // Reset mid-packet with a staged beat: rr_ptr is 1 here, so req 1 locks.
    @(negedge w_clk);
    drive(4'b0010, 4'b0000, 1'b0, 8'h20);
    #1;
    check("pre-reset req_ready", 64'(req_ready), 64'b0010);
    @(negedge w_clk);
    #1;
    check("pre-reset busy", 64'(busy), 64'd1);
    check("pre-reset w_en", 64'(w_en), 64'd1);
    w_rst_n = 1'b0;
    #1;
    check("in-reset w_en", 64'(w_en), 64'd0);
    check("in-reset busy", 64'(busy), 64'd0);
    check("in-reset grant_id", 64'(grant_id), 64'd0);
    check("in-reset data_in", 64'(data_in), 64'd0);
    drive(4'b0000, 4'b0000, 1'b0, 8'h00);
    @(posedge w_clk);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    drive(4'b0011, 4'b0011, 1'b0, 8'h21);
    #1;
    check("post-reset req_ready", 64'(req_ready), 64'b0001);
    @(negedge w_clk);
    drive(4'b0000, 4'b0000, 1'b0, 8'h00);
    #1;
    check("post-reset w_en", 64'(w_en), 64'd1);
    check("post-reset data_in", 64'(data_in), 64'({4'd0, pay(0, 8'h21)}));
    check("post-reset busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
